// File: rtl/hgcal_input_quantizer.sv
// Quantizes signed samples to 2-bit codes and packs them into one frame-wide word, double-buffered.
// Latency: the frame's last sample is accepted at edge N; m_valid/m_data are valid right after edge N.
// Backpressure: a finished frame waits in HOLD while the output is still occupied; s_ready drops until it moves.
//
// Ports:
//   clk, rst (async, active-low)
//   s_valid/s_ready/s_data/s_last : input sample stream, one sample per accepted beat
//   m_valid/m_ready/m_data        : packed frame output, sample k at bits [2k+1:2k]
//   err                           : one-cycle pulse after an early or missing s_last
module hgcal_input_quantizer #(
  parameter int                          NUM_INPUTS = 48,
  parameter int                          IN_WIDTH   = 16,
  parameter logic signed [IN_WIDTH-1:0]  T0         = IN_WIDTH'(-8192),
  parameter logic signed [IN_WIDTH-1:0]  T1         = IN_WIDTH'(0),
  parameter logic signed [IN_WIDTH-1:0]  T2         = IN_WIDTH'(8192)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [IN_WIDTH-1:0]   s_data,
  input  logic                         s_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [2*NUM_INPUTS-1:0]      m_data,
  output logic                         err
);

  localparam int              IDX_W    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int              DW       = 2 * NUM_INPUTS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_RESYNC = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DW-1:0]    fill_q, fill_d;
  logic [DW-1:0]    m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             s_ready_q, s_ready_d;
  logic             err_q, err_d;

  logic [1:0]       code;
  logic             accept;
  logic             out_free;

  // Thermometer count of thresholds reached; signed compare on both sides.
  always_comb begin
    code = {1'b0, (s_data >= T0)} + {1'b0, (s_data >= T1)} + {1'b0, (s_data >= T2)};
  end

  assign accept   = s_valid && s_ready_q;
  // The output slot can take a new frame if empty or being drained on this edge.
  assign out_free = !m_valid_q || m_ready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    fill_d    = fill_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q && !m_ready;
    err_d     = 1'b0;

    unique case (state_q)
      ST_FILL: begin
        if (accept) begin
          for (int k = 0; k < NUM_INPUTS; k++) begin
            if (idx_q == IDX_W'(k)) begin
              fill_d[2*k +: 2] = code;
            end
          end
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (!s_last) begin
              err_d   = 1'b1;
              state_d = ST_RESYNC;
            end else if (out_free) begin
              // fill_d already carries the final code, so the frame lands with no bubble.
              m_data_d  = fill_d;
              m_valid_d = 1'b1;
            end else begin
              state_d = ST_HOLD;
            end
          end else if (s_last) begin
            idx_d = '0;
            err_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (out_free) begin
          m_data_d  = fill_q;
          m_valid_d = 1'b1;
          state_d   = ST_FILL;
        end
      end

      ST_RESYNC: begin
        // Dropped samples leave idx at 0; only a frame boundary ends the resync.
        if (accept && s_last) begin
          state_d = ST_FILL;
        end
      end

      default: begin
        state_d = ST_FILL;
        idx_d   = '0;
      end
    endcase

    // Registered from the next state so s_ready is already low on the cycle HOLD begins.
    s_ready_d = (state_d != ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_FILL;
      idx_q     <= '0;
      fill_q    <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      s_ready_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      fill_q    <= fill_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      s_ready_q <= s_ready_d;
      err_q     <= err_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign err     = err_q;

endmodule

// File: tb/tb_hgcal_input_quantizer.sv
// Bench for hgcal_input_quantizer with 4-sample frames.
// Directed steps cover quantization, streaming, backpressure, framing errors and reset;
// a randomized phase is checked against a frame-level reference model.
module tb_hgcal_input_quantizer;

  localparam int N = 4;
  localparam int W = 16;

  typedef logic signed [W-1:0] frame_t [N];

  logic                clk;
  logic                rst;
  logic                s_valid;
  logic                s_ready;
  logic signed [W-1:0] s_data;
  logic                s_last;
  logic                m_valid;
  logic                m_ready;
  logic [2*N-1:0]      m_data;
  logic                err;

  int n_chk  = 0;
  int n_fail = 0;

  int edge_vals [8] = '{-8193, -8192, -1, 0, 8191, 8192, -32768, 32767};

  hgcal_input_quantizer #(
    .NUM_INPUTS(N),
    .IN_WIDTH  (W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .s_last (s_last),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference quantizer: number of thresholds (-8192, 0, 8192) the sample reaches.
  function automatic int quant(input logic signed [W-1:0] x);
    int v;
    int c;
    v = x;
    c = 0;
    if (v >= -8192) c++;
    if (v >= 0)     c++;
    if (v >= 8192)  c++;
    return c;
  endfunction

  function automatic logic [2*N-1:0] pack(input frame_t f);
    logic [2*N-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r = r + ((2*N)'(quant(f[k])) << (2*k));
    return r;
  endfunction

  function automatic logic [W-1:0] rand_sample();
    if ($urandom % 3 == 0) return W'(edge_vals[$urandom % 8]);
    return W'($urandom);
  endfunction

  task automatic rand_frame(output frame_t f);
    for (int k = 0; k < N; k++) f[k] = rand_sample();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one sample and returns just after the edge that accepted it.
  task automatic send(input logic [W-1:0] d, input logic l);
    int w;
    w = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && w < 50) begin
      tick();
      w++;
    end
    if (!s_ready) chk("send_timeout_s_ready", s_ready, 1);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input frame_t f);
    for (int k = 0; k < N; k++) send(f[k], k == N - 1);
  endtask

  frame_t fa, fb, fc;
  frame_t bb [3];

  // Reference-model state for the random phase
  int             cur_n;
  bit             resync;
  logic [2*N-1:0] cur_frame;
  logic [2*N-1:0] exp_q [$];
  bit             acc, hs, hold_now, nat, exp_err;
  logic [2*N-1:0] prev_data;
  logic           cur_last;
  logic [W-1:0]   cur_d;

  initial begin
    rst     = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("reset_s_ready", s_ready, 0);
    chk("reset_m_valid", m_valid, 0);
    chk("reset_m_data", m_data, 0);
    chk("reset_err", err, 0);
    rst = 1'b1;
    chk("release_s_ready_before_edge", s_ready, 0);
    tick();
    chk("release_s_ready_after_edge", s_ready, 1);

    // Quantization pattern 1
    send(W'(-20000), 1'b0);
    send(W'(-8192), 1'b0);
    send(W'(-1), 1'b0);
    send(W'(0), 1'b1);
    chk("q1_m_valid", m_valid, 1);
    chk("q1_m_data", m_data, 8'b10_01_01_00);
    chk("q1_err", err, 0);
    m_ready = 1'b1;
    tick();
    chk("q1_drained", m_valid, 0);
    m_ready = 1'b0;

    // Quantization pattern 2
    send(W'(8191), 1'b0);
    send(W'(8192), 1'b0);
    send(W'(32767), 1'b0);
    send(W'(-32768), 1'b1);
    chk("q2_m_valid", m_valid, 1);
    chk("q2_m_data", m_data, 8'b00_11_11_10);
    m_ready = 1'b1;
    tick();
    chk("q2_drained", m_valid, 0);

    // Back-to-back frames with m_ready held high
    for (int f = 0; f < 3; f++) rand_frame(bb[f]);
    for (int i = 0; i < 3 * N; i++) begin
      s_valid = 1'b1;
      s_data  = bb[i / N][i % N];
      s_last  = (i % N == N - 1);
      chk("b2b_s_ready", s_ready, 1);
      tick();
      chk("b2b_m_valid", m_valid, (i % N == N - 1));
      if (i % N == N - 1) chk("b2b_m_data", m_data, pack(bb[i / N]));
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    tick();
    chk("b2b_idle_m_valid", m_valid, 0);

    // Backpressure: A pending, B completes into HOLD
    m_ready = 1'b0;
    rand_frame(fa);
    rand_frame(fb);
    send_frame(fa);
    chk("bp_a_valid", m_valid, 1);
    chk("bp_a_data", m_data, pack(fa));
    for (int k = 0; k < N - 1; k++) send(fb[k], 1'b0);
    s_valid = 1'b1;
    s_data  = fb[N-1];
    s_last  = 1'b1;
    chk("bp_b_last_s_ready", s_ready, 1);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("bp_hold_s_ready", s_ready, 0);
    chk("bp_hold_a_data", m_data, pack(fa));
    chk("bp_hold_a_valid", m_valid, 1);
    tick();
    tick();
    chk("bp_hold2_s_ready", s_ready, 0);
    chk("bp_hold2_a_data", m_data, pack(fa));
    m_ready = 1'b1;
    tick();
    chk("bp_b_valid", m_valid, 1);
    chk("bp_b_data", m_data, pack(fb));
    chk("bp_s_ready_back", s_ready, 1);
    tick();
    chk("bp_b_drained", m_valid, 0);
    m_ready = 1'b0;

    // Early s_last on the 2nd sample
    send(W'(100), 1'b0);
    send(W'(200), 1'b1);
    chk("early_err", err, 1);
    chk("early_no_output", m_valid, 0);
    tick();
    chk("early_err_one_cycle", err, 0);
    rand_frame(fc);
    send_frame(fc);
    chk("early_next_valid", m_valid, 1);
    chk("early_next_data", m_data, pack(fc));
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;

    // Missing s_last on the 4th sample, then resync
    for (int k = 0; k < N; k++) send(W'(1000 * k), 1'b0);
    chk("miss_err", err, 1);
    chk("miss_no_output", m_valid, 0);
    tick();
    chk("miss_err_one_cycle", err, 0);
    send(W'(5), 1'b0);
    chk("resync_drop_err", err, 0);
    send(W'(6), 1'b0);
    send(W'(7), 1'b1);
    chk("resync_end_err", err, 0);
    chk("resync_no_output", m_valid, 0);
    rand_frame(fc);
    send_frame(fc);
    chk("resync_clean_valid", m_valid, 1);
    chk("resync_clean_data", m_data, pack(fc));

    // Reset with a frame pending and a partial frame filling
    send(W'(300), 1'b0);
    send(W'(400), 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_mid_m_valid", m_valid, 0);
    chk("rst_mid_s_ready", s_ready, 0);
    chk("rst_mid_m_data", m_data, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("rst_release_s_ready", s_ready, 1);
    rand_frame(fc);
    send_frame(fc);
    chk("rst_fresh_valid", m_valid, 1);
    chk("rst_fresh_data", m_data, pack(fc));
    m_ready = 1'b1;
    tick();

    // Randomized traffic against the frame-level model
    cur_n     = 0;
    resync    = 1'b0;
    cur_frame = '0;
    for (int i = 0; i < 2400; i++) begin
      if (i < 2350) begin
        s_valid = ($urandom % 10) < 8;
        m_ready = ($urandom % 10) < 7;
        nat     = resync ? ($urandom % 4 == 0) : (cur_n == N - 1);
        s_last  = ($urandom % 12 == 0) ? !nat : nat;
        s_data  = rand_sample();
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
      end
      acc       = s_valid && s_ready;
      hs        = m_valid && m_ready;
      hold_now  = m_valid && !m_ready;
      prev_data = m_data;
      cur_last  = s_last;
      cur_d     = s_data;
      tick();

      if (hs) begin
        n_chk++;
        assert (exp_q.size() > 0) else begin
          n_fail++;
          $error("FAIL rand_unexpected_frame: observed %0h expected none", prev_data);
        end
        if (exp_q.size() > 0) chk("rand_frame_data", prev_data, exp_q.pop_front());
      end
      if (hold_now) begin
        chk("rand_hold_valid", m_valid, 1);
        chk("rand_hold_data", m_data, prev_data);
      end

      exp_err = 1'b0;
      if (acc) begin
        if (resync) begin
          if (cur_last) resync = 1'b0;
        end else begin
          cur_frame[2*cur_n +: 2] = 2'(quant(cur_d));
          cur_n++;
          if (cur_n < N && cur_last) begin
            exp_err = 1'b1;
            cur_n   = 0;
          end else if (cur_n == N) begin
            if (cur_last) exp_q.push_back(cur_frame);
            else begin
              exp_err = 1'b1;
              resync  = 1'b1;
            end
            cur_n = 0;
          end
        end
      end
      chk("rand_err", err, exp_err);
    end
    chk("rand_all_frames_delivered", exp_q.size(), 0);
    chk("rand_final_m_valid", m_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
